// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter loading one shared byte register with valid/ready output.
// Optional per-requester saturating grant counters when REG_SHARE_STATS_EN is defined.
module reg_share_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              flush,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic [PW-1:0]     out_src,
  input  logic              out_ready
`ifdef REG_SHARE_STATS_EN
  ,
  output logic [8*NREQ-1:0] grant_cnt
`endif
);
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] j;
  logic          ld;
  // scan from the highest offset down so the nearest requester to rr_ptr wins last
  always_comb begin
    win = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = PW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (req[j]) win = j;
    end
  end
  assign ld = rst & ~flush & (~out_valid | out_ready) & (|req);
  assign gnt = ld ? (NREQ'(1) << win) : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= 8'h00;
      out_valid <= 1'b0;
      out_src <= '0;
      rr_ptr <= '0;
    end else if (ld) begin
      out_data <= req_data[{win, 3'b000} +: 8];
      out_src <= win;
      out_valid <= 1'b1;
      rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef REG_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && grant_cnt[8*i +: 8] != 8'hFF) grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed self-checking bench for reg_share_arbiter (NREQ=4).
module tb_reg_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        flush;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_src;
  logic        out_ready;
  int checks = 0;
  int failures = 0;
`ifdef REG_SHARE_STATS_EN
  logic [31:0] grant_cnt;
`endif

  reg_share_arbiter #(.NREQ(4), .PW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_src(out_src), .out_ready(out_ready)
`ifdef REG_SHARE_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".src"}, 32'(out_src), 32'(s));
  endtask

  initial begin
    rst = 1'b0; req = 4'b1111; req_data = 32'hA3A2A1A0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr.gnt0", 32'(gnt), 32'b0001);
    // continuous requests: grant order 0,1,2,3,0 with no idle cycle
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_out($sformatf("rr%0d", n), 1'b1, 8'hA0 + 8'(n % 4), 2'(n % 4));
      chk($sformatf("rr%0d.gnt", n), 32'(gnt), 32'(4'b0001 << ((n + 1) % 4)));
    end
    // rr_ptr=1 now; backpressure
    req = 4'b0100; req_data = 32'h005C0000; #1;
    chk("bp.gnt", 32'(gnt), 32'b0100);
    tick();
    chk_out("bp.load", 1'b1, 8'h5C, 2'd2);
    out_ready = 1'b0; #1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("bp.hold%0d.gnt", n), 32'(gnt), 32'h0);
      tick();
      chk_out($sformatf("bp.hold%0d", n), 1'b1, 8'h5C, 2'd2);
    end
    out_ready = 1'b1; req = 4'b0010; req_data = 32'h00007700; #1;
    chk("bp.rel.gnt", 32'(gnt), 32'b0010);
    tick();
    chk_out("bp.rel", 1'b1, 8'h77, 2'd1);
    // rr_ptr=2: grant 2 to move rr_ptr to 3, then skip-and-wrap
    req = 4'b0100; req_data = 32'h00330000; #1;
    chk("sw.g2", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0010; req_data = 32'h00001100; #1;
    chk("sw.g1", 32'(gnt), 32'b0010);
    tick();
    chk_out("sw.g1", 1'b1, 8'h11, 2'd1);
    req = 4'b0001; req_data = 32'h00000022; #1;
    chk("sw.g0", 32'(gnt), 32'b0001);
    tick();
    chk_out("sw.g0", 1'b1, 8'h22, 2'd0);
    req = 4'b1111; req_data = 32'hD3D2D1D0; #1;
    chk("sw.ptr1", 32'(gnt), 32'b0010);
    tick();
    // FULL with src1, rr_ptr=2; stall then flush
    req = 4'b0000; out_ready = 1'b0;
    tick();
    chk_out("fl.full", 1'b1, 8'hD1, 2'd1);
    flush = 1'b1; req = 4'b1000; req_data = 32'hF0000000; #1;
    chk("fl.gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("fl.empty", 1'b0, 8'hD1, 2'd1);
    flush = 1'b0; req = 4'b1111; #1;
    chk("fl.ptr", 32'(gnt), 32'b0100);
    req = 4'b1000; #1;
    chk("fl.g3", 32'(gnt), 32'b1000);
    tick();
    chk_out("fl.g3", 1'b1, 8'hF0, 2'd3);
    // asynchronous reset mid-cycle while FULL
    #2 rst = 1'b0; #1;
    chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
    chk("mid.rst.gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1; #1;
    chk("mid.rst.first", 32'(gnt), 32'b0001);
`ifdef REG_SHARE_STATS_EN
    rst = 1'b0; #1;
    chk("st.clr", grant_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1; req = 4'b0100; req_data = 32'h00990000;
    for (int n = 0; n < 300; n++) tick();
    chk("st.sat", grant_cnt, 32'h00FF0000);
    flush = 1'b1;
    tick();
    flush = 1'b0; req = 4'b0000; #1;
    chk("st.flush", grant_cnt, 32'h00FF0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
